// File: rtl/cpu_dma.sv
// Multi-channel memory-to-port DMA that halts the CPU at an instruction boundary
// and moves bytes with one read/write cycle pair per byte.
module cpu_dma #(
  parameter int                  CHANNELS = 2,
  parameter int                  LEN_W    = 8,
  parameter logic [CHANNELS-1:0] DST_INC  = '0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        ce,
  input  logic                        m0,
  input  logic [CHANNELS-1:0]         req,
  input  logic [CHANNELS*16-1:0]      src,
  input  logic [CHANNELS*16-1:0]      dst,
  input  logic [CHANNELS*LEN_W-1:0]   len,
  input  logic [7:0]                  I,
  output logic                        halt,
  output logic [15:0]                 A,
  output logic [7:0]                  D,
  output logic                        R,
  output logic                        W,
  output logic [CHANNELS-1:0]         busy,
  output logic [CHANNELS-1:0]         done
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HALT, S_ALIGN, S_READ, S_WRITE} state_t;

  state_t              r_state;
  logic                r_parity;
  logic                r_halt;
  logic                r_rd;
  logic                r_wr;
  logic [15:0]         r_a;
  logic [7:0]          r_d;
  logic [CHANNELS-1:0] r_busy;
  logic [CHANNELS-1:0] r_done;
  logic [CW-1:0]       r_ch;
  logic [15:0]         r_src [CHANNELS];
  logic [15:0]         r_dst [CHANNELS];
  logic [LEN_W:0]      r_cnt [CHANNELS];

  logic [15:0]         w_src_in [CHANNELS];
  logic [15:0]         w_dst_in [CHANNELS];
  logic [LEN_W-1:0]    w_len_in [CHANNELS];
  logic [CW-1:0]       w_first;
  logic [CW-1:0]       w_other;
  logic                w_other_any;
  logic                w_last;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_slice
      assign w_src_in[gi] = src[gi*16 +: 16];
      assign w_dst_in[gi] = dst[gi*16 +: 16];
      assign w_len_in[gi] = len[gi*LEN_W +: LEN_W];
    end
  endgenerate

  // Scan high to low so the lowest-index match wins.
  always_comb begin
    w_first     = '0;
    w_other     = '0;
    w_other_any = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (r_busy[k]) w_first = CW'(k);
      if (r_busy[k] && (CW'(k) != r_ch)) begin
        w_other     = CW'(k);
        w_other_any = 1'b1;
      end
    end
  end

  assign w_last = (r_cnt[r_ch] == (LEN_W+1)'(1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_parity <= 1'b0;
      r_halt   <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_a      <= '0;
      r_d      <= '0;
      r_busy   <= '0;
      r_done   <= '0;
      r_ch     <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        r_src[k] <= '0;
        r_dst[k] <= '0;
        r_cnt[k] <= '0;
      end
    end else if (ce) begin
      r_parity <= ~r_parity;
      r_done   <= '0;
      // A zero length field means a full 2^LEN_W byte block, hence the extra count bit.
      for (int k = 0; k < CHANNELS; k++) begin
        if (req[k] && !r_busy[k]) begin
          r_src[k]  <= w_src_in[k];
          r_dst[k]  <= w_dst_in[k];
          r_cnt[k]  <= {(w_len_in[k] == '0), w_len_in[k]};
          r_busy[k] <= 1'b1;
        end
      end
      unique case (r_state)
        S_IDLE: begin
          if (|r_busy) begin
            r_state <= S_WAIT;
            r_ch    <= w_first;
          end
        end
        S_WAIT: begin
          if (m0) begin
            r_state <= S_HALT;
            r_halt  <= 1'b1;
          end
        end
        S_HALT: begin
          // ALIGN keeps every first READ on the same parity phase.
          if (r_parity) begin
            r_state <= S_ALIGN;
          end else begin
            r_state <= S_READ;
            r_a     <= r_src[r_ch];
            r_rd    <= 1'b1;
          end
        end
        S_ALIGN: begin
          r_state <= S_READ;
          r_a     <= r_src[r_ch];
          r_rd    <= 1'b1;
        end
        S_READ: begin
          r_state <= S_WRITE;
          r_d     <= I;
          r_a     <= r_dst[r_ch];
          r_rd    <= 1'b0;
          r_wr    <= 1'b1;
          if (w_last) r_done[r_ch] <= 1'b1;
        end
        S_WRITE: begin
          r_wr        <= 1'b0;
          r_src[r_ch] <= r_src[r_ch] + 16'd1;
          r_cnt[r_ch] <= r_cnt[r_ch] - (LEN_W+1)'(1);
          if (DST_INC[r_ch]) r_dst[r_ch] <= r_dst[r_ch] + 16'd1;
          if (!w_last) begin
            r_state <= S_READ;
            r_a     <= r_src[r_ch] + 16'd1;
            r_rd    <= 1'b1;
          end else begin
            r_busy[r_ch] <= 1'b0;
            if (w_other_any) begin
              r_ch    <= w_other;
              r_state <= S_READ;
              r_a     <= r_src[w_other];
              r_rd    <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_halt  <= 1'b0;
              r_a     <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes and done are qualified by ce so a stalled CPU cycle never repeats them.
  assign halt = r_halt;
  assign A    = r_a;
  assign D    = r_d;
  assign R    = r_rd & ce;
  assign W    = r_wr & ce;
  assign busy = r_busy;
  assign done = r_done & {CHANNELS{ce}};

endmodule

// File: tb/tb_cpu_dma.sv
// Scoreboard bench for cpu_dma: stimulus queues expected bus cycles, a forked
// monitor pops and compares them on every strobe and measures halt runs.
module tb_cpu_dma;
  localparam int             CH   = 2;
  localparam int             LW   = 8;
  localparam logic [CH-1:0]  DINC = 2'b10;

  typedef struct {
    int            kind;
    logic [15:0]   addr;
    logic [7:0]    data;
    logic [CH-1:0] dn;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              ce;
  logic              m0;
  logic [CH-1:0]     req;
  logic [CH*16-1:0]  src;
  logic [CH*16-1:0]  dst;
  logic [CH*LW-1:0]  len;
  logic [7:0]        I;
  logic              halt;
  logic [15:0]       A;
  logic [7:0]        D;
  logic              R;
  logic              W;
  logic [CH-1:0]     busy;
  logic [CH-1:0]     done;

  exp_t exp_q[$];
  int   halt_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   wr_total = 0;
  logic tb_par;
  logic [CH-1:0] dinc_v = DINC;

  cpu_dma #(.CHANNELS(CH), .LEN_W(LW), .DST_INC(DINC)) dut (
    .clock(clock), .reset_n(reset_n), .ce(ce), .m0(m0), .req(req),
    .src(src), .dst(dst), .len(len), .I(I), .halt(halt), .A(A), .D(D),
    .R(R), .W(W), .busy(busy), .done(done)
  );

  always #20 clock = ~clock;

  function automatic logic [7:0] mem_data(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5C;
  endfunction

  assign I = mem_data(A);

  always @(posedge clock) begin
    if (!reset_n) tb_par <= 1'b0;
    else if (ce) tb_par <= ~tb_par;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic expect_item(input int kind, input logic [15:0] addr, input logic [7:0] data,
                             input logic [CH-1:0] dn);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_strobe: got kind %0d addr %04h, required nothing", kind, addr);
    end else begin
      e = exp_q.pop_front();
      chk("kind", kind, e.kind);
      if (kind == 0) chk("rd_addr", addr, e.addr);
      if (kind == 1) begin
        chk("wr_addr", addr, e.addr);
        chk("wr_data", data, e.data);
      end
      if (kind == 2) chk("done_vec", dn, e.dn);
    end
  endtask

  task automatic monitor();
    int   hrun = 0;
    logic prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        hrun = 0;
        prev = 1'b0;
      end else begin
        if ((R || W || (|done)) && !ce) chk("strobe_without_ce", ce, 1);
        if (R) expect_item(0, A, 8'h00, '0);
        if (W) begin
          expect_item(1, A, D, '0);
          wr_total++;
        end
        if (|done) expect_item(2, 16'h0, 8'h00, done);
        if (!halt && prev) halt_q.push_back(hrun);
        hrun = halt ? hrun + 1 : 0;
        prev = halt;
      end
    end
  endtask

  task automatic load(input int ch, input logic [15:0] s, input logic [15:0] d, input logic [LW-1:0] l);
    src[ch*16 +: 16] = s;
    dst[ch*16 +: 16] = d;
    len[ch*LW +: LW] = l;
  endtask

  task automatic push_xfer(input int ch, input logic [15:0] s, input logic [15:0] d, input int n);
    exp_t e;
    logic [15:0] sa;
    logic [15:0] da;
    sa = s;
    da = d;
    for (int i = 0; i < n; i++) begin
      e.kind = 0; e.addr = sa; e.data = 8'h00;        e.dn = '0; exp_q.push_back(e);
      e.kind = 1; e.addr = da; e.data = mem_data(sa); e.dn = '0; exp_q.push_back(e);
      sa = sa + 16'd1;
      if (dinc_v[ch]) da = da + 16'd1;
    end
    e.kind = 2; e.addr = 16'h0; e.data = 8'h00; e.dn = CH'(1) << ch;
    exp_q.push_back(e);
  endtask

  task automatic req_pulse(input logic [CH-1:0] r);
    req = r;
    cyc();
    req = '0;
  endtask

  task automatic fire_m0(input bit even);
    int n = 0;
    repeat (3) cyc();
    while ((tb_par != (even ? 1'b0 : 1'b1)) && n < 4) begin
      cyc();
      n++;
    end
    m0 = 1'b1;
    cyc();
    m0 = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int n = 0;
    while (!(exp_q.size() == 0 && !halt && busy == '0) && n < budget) begin
      if (toggle) ce = ~ce;
      cyc();
      n++;
    end
    ce = 1'b1;
    chk("completion_timeout", (n < budget), 1);
    if (n >= budget) exp_q.delete();
    repeat (2) cyc();
  endtask

  task automatic chk_halt(input string nm, input int exp);
    if (halt_q.size() == 0) chk("halt_run_seen", 0, 1);
    else chk("halt_len", halt_q.pop_front(), exp);
    chk("halt_single_run", halt_q.size(), 0);
    halt_q.delete();
    $display("xfer %s: expected halt run %0d cycles", nm, exp);
  endtask

  initial begin
    int base;
    int n;
    reset_n = 1'b0; ce = 1'b1; m0 = 1'b0; req = '1;
    src = '0; dst = '0; len = '0;
    fork
      monitor();
    join_none
    repeat (3) cyc();
    req = '0;
    reset_n = 1'b1;
    cyc();
    chk("rst_halt", halt, 0);
    chk("rst_A", A, 0);
    chk("rst_D", D, 0);
    chk("rst_R", R, 0);
    chk("rst_W", W, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    cyc();
    chk("req_in_reset_dropped", busy, 0);

    // 256 bytes, fixed destination, m0 on an even cycle: ALIGN inserted.
    load(0, 16'h0200, 16'h2004, 8'd0);
    req_pulse(2'b01);
    chk("busy_after_req", busy, 2'b01);
    push_xfer(0, 16'h0200, 16'h2004, 256);
    fire_m0(1'b1);
    wait_done(1200, 1'b0);
    chk_halt("ch0_256_even", 514);

    // Same transfer with m0 on an odd cycle: no ALIGN.
    load(0, 16'h0200, 16'h2004, 8'd0);
    req_pulse(2'b01);
    push_xfer(0, 16'h0200, 16'h2004, 256);
    fire_m0(1'b0);
    wait_done(1200, 1'b0);
    chk_halt("ch0_256_odd", 513);

    // Incrementing destination with source wrap FFFF -> 0000.
    load(1, 16'hFFFF, 16'h0300, 8'd2);
    req_pulse(2'b10);
    push_xfer(1, 16'hFFFF, 16'h0300, 2);
    fire_m0(1'b1);
    wait_done(100, 1'b0);
    chk_halt("ch1_wrap", 6);

    // Both channels requested together: ch0 then ch1 back to back under one halt.
    load(0, 16'h1000, 16'h4000, 8'd2);
    load(1, 16'h1100, 16'h5000, 8'd3);
    req_pulse(2'b11);
    push_xfer(0, 16'h1000, 16'h4000, 2);
    push_xfer(1, 16'h1100, 16'h5000, 3);
    fire_m0(1'b0);
    wait_done(100, 1'b0);
    chk_halt("ch0_ch1_chain", 11);

    // ce toggling during the transfer: same bus sequence, strobes only with ce=1.
    load(0, 16'h0300, 16'h2010, 8'd4);
    req_pulse(2'b01);
    push_xfer(0, 16'h0300, 16'h2010, 4);
    fire_m0(1'b1);
    wait_done(200, 1'b1);
    halt_q.delete();
    $display("xfer ce_toggle: bus sequence checked");

    // Reset after ten bytes of a 256-byte transfer.
    load(0, 16'h0200, 16'h2004, 8'd0);
    req_pulse(2'b01);
    push_xfer(0, 16'h0200, 16'h2004, 256);
    fire_m0(1'b0);
    base = wr_total;
    n = 0;
    while ((wr_total - base) < 10 && n < 100) begin
      cyc();
      n++;
    end
    chk("ten_writes_reached", (n < 100), 1);
    reset_n = 1'b0;
    exp_q.delete();
    cyc();
    chk("abort_halt", halt, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_A", A, 0);
    reset_n = 1'b1;
    cyc();
    chk("abort_no_done", done, 0);
    chk("abort_still_idle", halt, 0);
    halt_q.delete();
    $display("xfer abort: reset at byte 10");

    load(0, 16'h0A00, 16'h2100, 8'd5);
    req_pulse(2'b01);
    push_xfer(0, 16'h0A00, 16'h2100, 5);
    fire_m0(1'b1);
    wait_done(100, 1'b0);
    chk_halt("after_abort", 12);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_dma.md
CPU_DMA -- requirements
Module: cpu_dma

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent DMA channels (1..4).
REQ-002 Parameter LEN_W, default 8: transfer-length field width; length 0 encodes 2^LEN_W bytes.
REQ-003 Parameter DST_INC, default 0 (CHANNELS bits): bit k=1 means the channel k destination increments per byte; bit k=0 means a fixed port address.
REQ-004 clock  in  1  system clock (25 MHz).
REQ-005 reset_n  in  1  reset, synchronous, active-low; clock clock.
REQ-006 ce  in  1  CPU clock enable; all state advances only when ce=1.
REQ-007 m0  in  1  CPU opcode-fetch strobe (instruction boundary).
REQ-008 req  in  CHANNELS  per-channel start pulse, sampled when ce=1.
REQ-009 src  in  CHANNELS*16  per-channel source start address, latched on req.
REQ-010 dst  in  CHANNELS*16  per-channel destination address, latched on req.
REQ-011 len  in  CHANNELS*LEN_W  per-channel byte count, latched on req.
REQ-012 I  in  8  read data from the bus.
REQ-013 halt  out  1  when 1, the CPU ce is gated off and the DMA owns the bus.
REQ-014 A  out  16  DMA bus address.
REQ-015 D  out  8  DMA write data.
REQ-016 R  out  1  read strobe, one cycle.
REQ-017 W  out  1  write strobe, one cycle.
REQ-018 busy  out  CHANNELS  channel pending or active.
REQ-019 done  out  CHANNELS  one-cycle pulse when the channel's last write issues.

Function
REQ-020 The block SHALL implement states IDLE, WAIT, HALT, ALIGN, READ, WRITE; a transition occurs only on a ce=1 cycle.
REQ-021 req[k] SHALL latch src/dst/len for channel k and set busy[k] in the next cycle.
REQ-022 req[k] while channel k is active SHALL be ignored; req on other channels SHALL queue.
REQ-023 From IDLE with any busy channel set, the FSM SHALL go to WAIT and select the lowest-index busy channel.
REQ-024 The FSM SHALL leave WAIT only on a ce=1 cycle with m0=1, entering HALT; halt SHALL go 1 in that cycle and stay 1 through the final WRITE.
REQ-025 HALT SHALL last one cycle as a dummy bus cycle with R=W=0.
REQ-026 An internal parity bit toggles on every ce=1 cycle; if parity is odd on exiting HALT, the FSM SHALL insert one ALIGN cycle, so that the first READ falls on an even cycle.
REQ-027 READ SHALL drive A=current source and R=1, then go to WRITE.
REQ-028 WRITE SHALL capture I into D and drive A=current destination and W=1.
REQ-029 After each WRITE the source SHALL increment modulo 2^16, the destination SHALL increment only if DST_INC[k]=1, and the count SHALL decrement.
REQ-030 When the count reaches 0, WRITE SHALL pulse done[k] and clear busy[k]; if another channel is busy, the FSM SHALL go directly to READ for that channel with halt held; otherwise it goes to IDLE and halt=0 in the next cycle.
REQ-031 Total halt duration for N bytes SHALL be 1 + align + 2N cycles (513 or 514 for N=256).
REQ-032 With ce=0 all outputs SHALL hold, except R, W and done, which SHALL be 0.
REQ-033 When not in READ/WRITE, the block SHALL drive A=0, R=0 and W=0.
REQ-034 Source address wrap from FFFF to 0000 SHALL occur silently, with no flag.

Reset
REQ-035 reset_n=0 SHALL force IDLE and set halt=0, A=0, D=0, R=0, W=0, busy=0, done=0 and parity=0, aborting any transfer with no completion pulse.
REQ-036 req asserted during reset SHALL be discarded.

Verification
REQ-037 ch0 req, src=0x0200, dst=0x2004, len=0, DST_INC=0, m0 on an even cycle -> halt for 514 cycles; 256 writes to 0x2004 with data from 0x0200..0x02FF; one done[0] pulse.
REQ-038 Same transfer with m0 on an odd cycle -> halt for 513 cycles, no ALIGN.
REQ-039 req[0] and req[1] in the same cycle, lengths 2 and 3 -> ch0 runs first, then ch1 follows with no halt drop; a single HALT cycle; done[0] precedes done[1].
REQ-040 ce toggling 1/0 during the transfer -> same sequence of A/D/R/W; strobes appear only on ce=1 cycles.
REQ-041 reset_n=0 at byte 10 of 256 -> next cycle halt=0 and busy=0, no done pulse; a fresh req afterwards completes normally.
REQ-042 DST_INC[1]=1, src=0xFFFF, dst=0x0300, len=2 -> reads 0xFFFF then 0x0000; writes 0x0300 then 0x0301.
